hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage MIPS datapath (IF/ID/EX/MEM/WB).
- Replaces the hardwired stall=0 and jump_cs=0 with generated stall, flush and redirect controls.
- Detects load-use hazards, taken jumps/branches resolved in EX, and data-memory wait.
- Produces EX-stage operand forwarding selects and saturating performance counters.

Parameters:
BR_PENALTY, 2, cycles flush_id is asserted per taken jump, detection cycle included; legal range 1..7
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
ex_rs  in  5  rs of the instruction in EX
ex_rt  in  5  rt of the instruction in EX
ex_rd  in  5  destination register of the instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_jump_taken  in  1  EX resolved a taken jump/branch
mem_rd  in  5  destination register in MEM
mem_reg_write  in  1  MEM instruction writes a register
wb_rd  in  5  destination register in WB
wb_reg_write  in  1  WB instruction writes a register
mem_busy  in  1  data memory not ready this cycle
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID register
stall_ex  out  1  hold ID/EX register
stall_mem  out  1  hold EX/MEM register
flush_id  out  1  load bubble into IF/ID
flush_ex  out  1  load bubble into ID/EX
flush_wb  out  1  load bubble into MEM/WB
pc_redirect  out  1  IF takes jump target (drives jump_cs)
fwd_a  out  2  EX operand A select: 00 regfile, 01 WB, 10 MEM
fwd_b  out  2  EX operand B select, same encoding
state  out  2  FSM state: 0 RUN, 1 LU_STALL, 2 BR_FLUSH, 3 MEM_WAIT
stall_cnt  out  CNT_W  cycles with stall_if=1, saturating
flush_cnt  out  CNT_W  taken jumps accepted, saturating

Behaviour:
- Reset (rst_n=0, asynchronous): state=RUN, br counter=0, stall_cnt=0, flush_cnt=0.
- While rst_n=0, all stall/flush/redirect outputs are 0 and fwd_a/fwd_b are 00.
- Control outputs are combinational from state and current inputs. State and counters are registered.
- load_use = ex_mem_read && ex_rd!=0 && (ex_rd==id_rs || (id_uses_rt && ex_rd==id_rt)).
- Priority within a cycle: mem_busy > ex_jump_taken > load_use.
- RUN, and MEM_WAIT with mem_busy=0 (identical behaviour):
  - mem_busy=1: freeze cycle (stall_if, stall_id, stall_ex, stall_mem, flush_wb = 1); next state MEM_WAIT.
  - else ex_jump_taken=1: pc_redirect=1, flush_id=1, flush_ex=1; flush_cnt++; br counter loads BR_PENALTY-1; next state BR_FLUSH if BR_PENALTY>1, else RUN.
  - else load_use=1: stall_if=1, stall_id=1, flush_ex=1; next state LU_STALL.
  - else: no controls asserted; next state RUN.
- MEM_WAIT with mem_busy=1: freeze cycle as above; stay in MEM_WAIT.
  - A jump or load-use present in EX stays frozen and is handled on the first cycle mem_busy=0.
- LU_STALL (exactly 1 cycle):
  - load_use and ex_jump_taken are ignored, since EX holds a bubble.
  - mem_busy=1: freeze cycle, next state MEM_WAIT; else no controls, next state RUN.
- BR_FLUSH:
  - flush_id=1; ex_jump_taken and load_use are ignored; br counter decrements.
  - Exit to RUN in the cycle after the counter reaches 0.
  - mem_busy=1: freeze cycle with flush_id held; counter does not decrement.
- Forwarding (combinational, every state), shown for A; B is identical using ex_rt:
  - fwd_a=10 if mem_reg_write && mem_rd!=0 && mem_rd==ex_rs.
  - else fwd_a=01 if wb_reg_write && wb_rd!=0 && wb_rd==ex_rs.
  - else fwd_a=00. MEM wins over WB.
- Register $0 never causes a hazard or a forward.
- Counters increment on the clock edge of a qualifying cycle and saturate at all-ones with no wrap.
- Reset mid-stall or mid-flush: outputs drop to 0 immediately; FSM returns to RUN.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs=5, no jump/busy -> stall_if=stall_id=flush_ex=1 for 1 cycle, state RUN→LU_STALL→RUN, stall_cnt=1; repeat with ex_rd=0 -> no stall.
- Jump, BR_PENALTY=2: ex_jump_taken=1 one cycle -> pc_redirect=1 and flush_ex=1 for 1 cycle, flush_id=1 for 2 cycles, flush_cnt=1, back to RUN on cycle 3.
- Priority: mem_busy=1 for 3 cycles with ex_jump_taken=1 and load_use true -> 3 freeze cycles, flush_wb=1, no redirect; jump handled on cycle 4; stall_cnt=3.
- Forwarding: ex_rs=7, mem_rd=7, wb_rd=7, both reg_write=1 -> fwd_a=10; clear mem_reg_write -> 01; set ex_rt=0, wb_rd=0 -> fwd_b=00.
- Saturation, CNT_W=4: hold mem_busy=1 for 20 cycles -> stall_cnt stops at 15.
- Reset in BR_FLUSH with BR_PENALTY=4: pull rst_n low mid-flush -> flush_id=0 immediately, state=0, counters=0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard control bus: pipeline-side status in, stall/flush/forward controls out.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic [4:0]       ex_rs;
    logic [4:0]       ex_rt;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_jump_taken;
    logic [4:0]       mem_rd;
    logic             mem_reg_write;
    logic [4:0]       wb_rd;
    logic             wb_reg_write;
    logic             mem_busy;
    logic             stall_if;
    logic             stall_id;
    logic             stall_ex;
    logic             stall_mem;
    logic             flush_id;
    logic             flush_ex;
    logic             flush_wb;
    logic             pc_redirect;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Pipeline datapath side.
    modport master (
        output id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_rd, ex_mem_read, ex_jump_taken,
        output mem_rd, mem_reg_write, wb_rd, wb_reg_write, mem_busy,
        input  stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb,
        input  pc_redirect, fwd_a, fwd_b, state, stall_cnt, flush_cnt
    );

    // Hazard control unit side.
    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_rd, ex_mem_read, ex_jump_taken,
        input  mem_rd, mem_reg_write, wb_rd, wb_reg_write, mem_busy,
        output stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb,
        output pc_redirect, fwd_a, fwd_b, state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard control for the 5-stage MIPS pipeline: load-use stalls, taken-jump flushes,
// data-memory wait freezes, EX operand forwarding and saturating event counters.
module hazard_ctrl #(
    parameter int unsigned BR_PENALTY = 2,
    parameter int unsigned CNT_W      = 16
) (
    input logic         clk,
    input logic         rst_n,
    hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StLuStall  = 2'd1,
        StBrFlush  = 2'd2,
        StMemWait  = 2'd3
    } state_e;

    localparam logic [2:0] BrReload = 3'(BR_PENALTY - 1);

    state_e           r_state;
    logic [2:0]       r_br_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic       w_load_use;
    logic       w_freeze;
    logic       w_jump_acc;
    logic       w_lu_acc;
    logic       w_in_brf;
    logic       w_stall_if;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    // Load in EX feeding a source of the instruction in ID; $0 is never a real dependency.
    assign w_load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                        ((bus.ex_rd == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));

    assign w_freeze = bus.mem_busy;

    // Decide which event is accepted this cycle; memory wait overrides everything.
    always_comb begin
        w_jump_acc = 1'b0;
        w_lu_acc   = 1'b0;
        w_in_brf   = 1'b0;
        unique case (r_state)
            StRun, StMemWait: begin
                if (!w_freeze) begin
                    if (bus.ex_jump_taken) begin
                        w_jump_acc = 1'b1;
                    end else if (w_load_use) begin
                        w_lu_acc = 1'b1;
                    end
                end
            end
            StLuStall: begin
                // EX holds the bubble inserted last cycle; nothing to act on.
            end
            StBrFlush: begin
                w_in_brf = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign w_stall_if = w_freeze || w_lu_acc;

    // Drive pipeline controls; everything is forced quiet while reset is held.
    always_comb begin
        bus.stall_if    = rst_n && w_stall_if;
        bus.stall_id    = rst_n && w_stall_if;
        bus.stall_ex    = rst_n && w_freeze;
        bus.stall_mem   = rst_n && w_freeze;
        bus.flush_wb    = rst_n && w_freeze;
        bus.flush_id    = rst_n && (w_jump_acc || w_in_brf);
        bus.flush_ex    = rst_n && (w_jump_acc || w_lu_acc);
        bus.pc_redirect = rst_n && w_jump_acc;
    end

    // Forwarding selects for EX operands; MEM result is newer than WB so it wins.
    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (bus.mem_reg_write && (bus.mem_rd != 5'd0) && (bus.mem_rd == bus.ex_rs)) begin
            w_fwd_a = 2'b10;
        end else if (bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.ex_rs)) begin
            w_fwd_a = 2'b01;
        end
        if (bus.mem_reg_write && (bus.mem_rd != 5'd0) && (bus.mem_rd == bus.ex_rt)) begin
            w_fwd_b = 2'b10;
        end else if (bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.ex_rt)) begin
            w_fwd_b = 2'b01;
        end
        bus.fwd_a = rst_n ? w_fwd_a : 2'b00;
        bus.fwd_b = rst_n ? w_fwd_b : 2'b00;
    end

    assign bus.state     = r_state;
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;

    // FSM, branch-penalty counter and saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StRun;
            r_br_cnt    <= 3'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_freeze) begin
                // A flush in progress keeps its place; the penalty counter is frozen too.
                if (r_state != StBrFlush) begin
                    r_state <= StMemWait;
                end
            end else begin
                unique case (r_state)
                    StRun, StMemWait: begin
                        if (w_jump_acc) begin
                            r_br_cnt <= BrReload;
                            r_state  <= (BR_PENALTY > 1) ? StBrFlush : StRun;
                        end else if (w_lu_acc) begin
                            r_state <= StLuStall;
                        end else begin
                            r_state <= StRun;
                        end
                    end
                    StLuStall: begin
                        r_state <= StRun;
                    end
                    StBrFlush: begin
                        if (r_br_cnt <= 3'd1) begin
                            r_br_cnt <= 3'd0;
                            r_state  <= StRun;
                        end else begin
                            r_br_cnt <= r_br_cnt - 3'd1;
                        end
                    end
                    default: begin
                        r_state <= StRun;
                    end
                endcase
            end

            if (w_stall_if && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_jump_acc && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

endmodule
